gic_modport: RTL and testbench
==============================

Name: gic_modport

Overview:
- Registered, level-sensitive interrupt aggregator.
- Collects N peripheral interrupt request lines and applies a static enable mask.
- Raises a single interrupt line to the CPU one clock after any enabled request is high.
- Reports the index of the winning source. It sits between the peripheral IRQ lines and the core's single interrupt input.

Parameters:
- N, 10: number of interrupt sources (legal 1..64).
- MASK, all ones (N bits): static per-source enable. Bit i = 1 enables source i.
- PRIO_MSB, 0: priority direction. 0 = lowest index wins; 1 = highest index wins.
- ID_W, derived as max(1, clog2(N)): width of int_id. Not user-overridable.

Ports:
- clk, input, 1: single clock. All logic updates on its rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- int_in, input, N: interrupt request lines. Level-sensitive; bit i high means source i requests.
- int_out, output, 1: aggregated interrupt to the CPU. Registered.
- int_id, output, ID_W: index of the highest-priority active source. Registered.

Behaviour:
- **Clocking and reset.** One clock domain. Reset is synchronous and active-low: it is sampled only on posedge clk. While rst_n = 0 at a posedge, int_out <= 0 and int_id <= 0. No asynchronous path exists.
- **Active vector.** active = int_in & MASK, computed combinationally.
- **int_out.** Each posedge with rst_n = 1: int_out <= |active.
  - Latency is exactly 1 cycle: any enabled request high at posedge k gives int_out = 1 after posedge k+1.
  - Deasserts exactly 1 cycle after all enabled requests are low.
  - No latching or stickiness: a one-cycle pulse on int_in gives a one-cycle pulse on int_out.
- **int_id.** Each posedge with rst_n = 1:
  - PRIO_MSB = 0: int_id <= index of the lowest set bit of active.
  - PRIO_MSB = 1: int_id <= index of the highest set bit of active.
  - If active == 0, int_id <= 0. Consumers qualify int_id with int_out.
- **Coherence.** int_out and int_id update on the same edge from the same sample of active.
- **Masked sources.** A source with MASK bit 0 never affects int_out or int_id, even when it is the only one high.
- **Simultaneous requests.** Priority resolves per the PRIO_MSB rule; no round-robin and no fairness.
- **Reset mid-operation.** If rst_n falls while requests are high, outputs are 0 after that posedge. They resume 1 cycle after the first posedge with rst_n = 1.
- **Edge cases.**
  - N = 1: int_id is 1 bit and is constantly 0.
  - X or Z on a masked bit must not propagate to the outputs.
- **No handshake.** There is no acknowledge. The source must hold its line until it is serviced.

Decomposition:
- Package gic_pkg holds:
  - function clog2_min1(n), which returns the ID width;
  - typedef for the source count limit (GIC_MAX_SRC = 64).
- One sub-module, gic_prio_enc: purely combinational.
  - Parameterised N and PRIO_MSB.
  - Inputs: vector.
  - Outputs: any (1 bit) and idx (ID_W).
- The top module instantiates gic_prio_enc and registers its outputs.

Test Plan:
- Reset: hold rst_n = 0 with int_in = 10'h3FF for 3 cycles -> int_out = 0 and int_id = 0 throughout. Release rst_n -> int_out = 1, int_id = 0 one cycle later.
- Single source: int_in = 10'h020 for 1 cycle -> next cycle int_out = 1, int_id = 5; the cycle after, int_out = 0, int_id = 0.
- Priority: int_in = 10'h28C with PRIO_MSB = 0 -> int_id = 2. Same stimulus with PRIO_MSB = 1 -> int_id = 9. int_out = 1 in both cases.
- Mask: MASK = 10'h3FE, int_in = 10'h001 -> int_out stays 0. Then int_in = 10'h003 -> int_out = 1, int_id = 1 next cycle.
- Sweep: walk a one-hot bit across bits 0..9 on consecutive cycles -> on each following cycle int_out = 1 and int_id equals the previous bit index. Check the property (|int_in) |=> int_out throughout.
- Mid-operation reset: int_in = 10'h100 held; assert rst_n = 0 for 1 cycle -> outputs 0 for that cycle, then int_out = 1, int_id = 8 on the cycle after release.

Source files
------------

// File: rtl/gic_pkg.sv
// Shared constants and helpers for the interrupt aggregator.
package gic_pkg;

    localparam int GIC_MAX_SRC = 64;

    // Wide enough to hold any legal source count (1..GIC_MAX_SRC).
    typedef logic [$clog2(GIC_MAX_SRC):0] gic_src_cnt_t;

    // Index width; a single source still gets a 1-bit id.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gic_modport_if.sv
// IRQ bundle between peripherals (master drives requests) and the aggregator.
interface gic_modport_if
    import gic_pkg::*;
#(
    parameter int N = 10
);
    localparam int ID_W = clog2_min1(N);

    logic [N-1:0]    int_in;
    logic            int_out;
    logic [ID_W-1:0] int_id;

    modport master (output int_in, input  int_out, input  int_id);
    modport slave  (input  int_in, output int_out, output int_id);
endinterface

// File: rtl/gic_prio_enc.sv
// Combinational fixed-priority encoder: lowest or highest set bit wins.
module gic_prio_enc
    import gic_pkg::*;
#(
    parameter int N        = 10,
    parameter bit PRIO_MSB = 1'b0,
    parameter int ID_W     = clog2_min1(N)
) (
    input  logic [N-1:0]    vec,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        any = |vec;
        idx = '0;
        // The last match in scan order wins, so scan away from the winning end.
        if (PRIO_MSB) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = ID_W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/gic_modport.sv
// Registered level-sensitive interrupt aggregator with static enable mask.
module gic_modport
    import gic_pkg::*;
#(
    parameter int           N        = 10,
    parameter logic [N-1:0] MASK     = '1,
    parameter bit           PRIO_MSB = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    gic_modport_if.slave  bus
);

    localparam int ID_W = clog2_min1(N);

    logic [N-1:0]    w_active;
    logic            w_any;
    logic [ID_W-1:0] w_idx;
    logic            r_int_out;
    logic [ID_W-1:0] r_int_id;

    // Masked bits are forced to 0 here so X/Z on them never reaches the encoder.
    assign w_active = bus.int_in & MASK;

    gic_prio_enc #(
        .N        (N),
        .PRIO_MSB (PRIO_MSB),
        .ID_W     (ID_W)
    ) u_prio_enc (
        .vec (w_active),
        .any (w_any),
        .idx (w_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_int_out <= 1'b0;
            r_int_id  <= '0;
        end else begin
            r_int_out <= w_any;
            r_int_id  <= w_idx;
        end
    end

    assign bus.int_out = r_int_out;
    assign bus.int_id  = r_int_id;

endmodule

// File: tb/tb_gic_modport.sv
// Directed bench: three aggregator variants (lsb-first, msb-first, bit0 masked).
module tb_gic_modport;

    logic       clk;
    logic       rst_n;
    logic [9:0] stim;
    int         checks;
    int         errors;

    gic_modport_if #(.N(10)) if0 ();
    gic_modport_if #(.N(10)) if1 ();
    gic_modport_if #(.N(10)) if2 ();

    assign if0.int_in = stim;
    assign if1.int_in = stim;
    assign if2.int_in = stim;

    gic_modport #(.N(10), .MASK(10'h3FF), .PRIO_MSB(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    gic_modport #(.N(10), .MASK(10'h3FF), .PRIO_MSB(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    gic_modport #(.N(10), .MASK(10'h3FE), .PRIO_MSB(1'b0)) dut_msk (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stim  = 10'h3FF;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (if0.int_out !== 1'b0 || if0.int_id !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got out=%0b id=%0d exp out=0 id=0", c, if0.int_out, if0.int_id);
            end
            checks++;
            if (if1.int_out !== 1'b0 || if1.int_id !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold_msb cyc %0d got out=%0b id=%0d exp out=0 id=0", c, if1.int_out, if1.int_id);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (if0.int_out !== 1'b1 || if0.int_id !== 4'd0) begin
            errors++;
            $display("FAIL reset_release got out=%0b id=%0d exp out=1 id=0", if0.int_out, if0.int_id);
        end
        checks++;
        if (if1.int_out !== 1'b1 || if1.int_id !== 4'd9) begin
            errors++;
            $display("FAIL reset_release_msb got out=%0b id=%0d exp out=1 id=9", if1.int_out, if1.int_id);
        end
        $display("reset: in=3FF held 3 cycles then released, out=%0b id=%0d", if0.int_out, if0.int_id);
    endtask

    task automatic test_single();
        stim = 10'h020;
        step();
        stim = 10'h000;
        checks++;
        if (if0.int_out !== 1'b1 || if0.int_id !== 4'd5) begin
            errors++;
            $display("FAIL single_on got out=%0b id=%0d exp out=1 id=5", if0.int_out, if0.int_id);
        end
        step();
        checks++;
        if (if0.int_out !== 1'b0 || if0.int_id !== 4'd0) begin
            errors++;
            $display("FAIL single_off got out=%0b id=%0d exp out=0 id=0", if0.int_out, if0.int_id);
        end
        $display("single: in=020 one-cycle pulse, trailing out=%0b id=%0d", if0.int_out, if0.int_id);
    endtask

    task automatic test_priority();
        stim = 10'h28C;
        step();
        checks++;
        if (if0.int_out !== 1'b1 || if0.int_id !== 4'd2) begin
            errors++;
            $display("FAIL prio_lsb got out=%0b id=%0d exp out=1 id=2", if0.int_out, if0.int_id);
        end
        checks++;
        if (if1.int_out !== 1'b1 || if1.int_id !== 4'd9) begin
            errors++;
            $display("FAIL prio_msb got out=%0b id=%0d exp out=1 id=9", if1.int_out, if1.int_id);
        end
        stim = 10'h00C;
        step();
        checks++;
        if (if0.int_id !== 4'd2 || if1.int_id !== 4'd3) begin
            errors++;
            $display("FAIL prio_pair got lsb=%0d msb=%0d exp lsb=2 msb=3", if0.int_id, if1.int_id);
        end
        stim = 10'h000;
        $display("priority: in=28C lsb id=2 msb id=9, in=00C lsb id=2 msb id=3");
    endtask

    task automatic test_mask();
        stim = 10'h001;
        step();
        checks++;
        if (if2.int_out !== 1'b0 || if2.int_id !== 4'd0) begin
            errors++;
            $display("FAIL mask_only got out=%0b id=%0d exp out=0 id=0", if2.int_out, if2.int_id);
        end
        checks++;
        if (if0.int_out !== 1'b1) begin
            errors++;
            $display("FAIL mask_unmasked_ref got out=%0b exp out=1", if0.int_out);
        end
        stim = 10'h003;
        step();
        checks++;
        if (if2.int_out !== 1'b1 || if2.int_id !== 4'd1) begin
            errors++;
            $display("FAIL mask_pair got out=%0b id=%0d exp out=1 id=1", if2.int_out, if2.int_id);
        end
        stim = 10'h000;
        $display("mask: bit0 masked, in=001 out=0, in=003 id=1");
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 10; i++) begin
            stim = 10'(1 << i);
            step();
            checks++;
            if (if0.int_out !== 1'b1 || if0.int_id !== 4'(i)) begin
                errors++;
                $display("FAIL sweep_lsb bit %0d got out=%0b id=%0d exp out=1 id=%0d", i, if0.int_out, if0.int_id, i);
            end
            checks++;
            if (if1.int_out !== 1'b1 || if1.int_id !== 4'(i)) begin
                errors++;
                $display("FAIL sweep_msb bit %0d got out=%0b id=%0d exp out=1 id=%0d", i, if1.int_out, if1.int_id, i);
            end
            $display("sweep: bit %0d out=%0b id=%0d", i, if0.int_out, if0.int_id);
        end
        stim = 10'h000;
        step();
        checks++;
        if (if0.int_out !== 1'b0 || if0.int_id !== 4'd0) begin
            errors++;
            $display("FAIL sweep_end got out=%0b id=%0d exp out=0 id=0", if0.int_out, if0.int_id);
        end
    endtask

    task automatic test_mid_reset();
        stim = 10'h100;
        step();
        checks++;
        if (if0.int_out !== 1'b1 || if0.int_id !== 4'd8) begin
            errors++;
            $display("FAIL midrst_pre got out=%0b id=%0d exp out=1 id=8", if0.int_out, if0.int_id);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (if0.int_out !== 1'b0 || if0.int_id !== 4'd0) begin
            errors++;
            $display("FAIL midrst_hold got out=%0b id=%0d exp out=0 id=0", if0.int_out, if0.int_id);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (if0.int_out !== 1'b1 || if0.int_id !== 4'd8) begin
            errors++;
            $display("FAIL midrst_resume got out=%0b id=%0d exp out=1 id=8", if0.int_out, if0.int_id);
        end
        checks++;
        if (if1.int_out !== 1'b1 || if1.int_id !== 4'd8) begin
            errors++;
            $display("FAIL midrst_resume_msb got out=%0b id=%0d exp out=1 id=8", if1.int_out, if1.int_id);
        end
        stim = 10'h000;
        $display("mid_reset: in=100, reset pulse, resume out=%0b id=%0d", if0.int_out, if0.int_id);
    endtask

    task automatic test_back_to_back();
        stim = 10'h200;
        step();
        stim = 10'h010;
        checks++;
        if (if0.int_out !== 1'b1 || if0.int_id !== 4'd9) begin
            errors++;
            $display("FAIL b2b_first got out=%0b id=%0d exp out=1 id=9", if0.int_out, if0.int_id);
        end
        step();
        stim = 10'h000;
        checks++;
        if (if0.int_out !== 1'b1 || if0.int_id !== 4'd4) begin
            errors++;
            $display("FAIL b2b_second got out=%0b id=%0d exp out=1 id=4", if0.int_out, if0.int_id);
        end
        step();
        checks++;
        if (if0.int_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop got out=%0b exp out=0", if0.int_out);
        end
        $display("back_to_back: in=200 then 010 then 000");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        stim   = 10'h000;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_sweep();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
